// File: rtl/udp_tx_arbiter_if.sv
// Signal bundle between the UDP TX arbiter and its mux/stack environment.
// The slave side is the arbiter; the master side drives the taps and handshakes.
interface udp_tx_arbiter_if #(
  parameter int S_COUNT     = 2,
  parameter int SEL_WIDTH   = $clog2(S_COUNT),
  parameter int COUNT_WIDTH = 16
);
  // Handshakes are observed only: a transfer happens in a cycle where valid
  // and ready are both high; the arbiter never drives either side of them.
  logic [S_COUNT-1:0]     req_hdr_valid;
  logic                   m_hdr_valid;
  logic                   m_hdr_ready;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   m_tlast;
  logic                   enable;
  logic [SEL_WIDTH-1:0]   select;
  logic [S_COUNT-1:0]     grant;
  logic                   busy;
  logic [COUNT_WIDTH-1:0] grant_count;

  modport master (
    output req_hdr_valid, m_hdr_valid, m_hdr_ready, m_tvalid, m_tready, m_tlast,
    input  enable, select, grant, busy, grant_count
  );

  modport slave (
    input  req_hdr_valid, m_hdr_valid, m_hdr_ready, m_tvalid, m_tready, m_tlast,
    output enable, select, grant, busy, grant_count
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Round-robin frame arbiter driving a UDP TX mux: one grant per frame, held
// from the header request until the last payload beat is accepted downstream.
module udp_tx_arbiter #(
  parameter int S_COUNT     = 2,
  parameter int SEL_WIDTH   = $clog2(S_COUNT),
  parameter int COUNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  udp_tx_arbiter_if.slave  bus,
  output logic [1:0]       state_o
);

  // Debug encoding on state_o: 0 idle, 1 waiting for header, 2 in payload.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   enable_q, enable_d;
  logic [SEL_WIDTH-1:0]   select_q, select_d;
  logic [S_COUNT-1:0]     grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [SEL_WIDTH-1:0]   ptr_q, ptr_d;

  logic                   hdr_hs;
  logic                   last_hs;
  logic                   found;
  logic [SEL_WIDTH-1:0]   win;
  int                     idx;

  assign hdr_hs  = bus.m_hdr_valid & bus.m_hdr_ready;
  assign last_hs = bus.m_tvalid & bus.m_tready & bus.m_tlast;

  // First requester at or after ptr, scanning upward with wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < S_COUNT; i++) begin
      idx = (int'(ptr_q) + i) % S_COUNT;
      if (!found && bus.req_hdr_valid[idx]) begin
        found = 1'b1;
        win   = SEL_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    select_d = select_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    count_d  = count_q;
    ptr_d    = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          select_d = win;
          grant_d  = {{(S_COUNT-1){1'b0}}, 1'b1} << win;
          enable_d = 1'b1;
          busy_d   = 1'b1;
          ptr_d    = (int'(win) == S_COUNT - 1) ? '0 : win + 1'b1;
          state_d  = ST_HDR;
        end
      end
      ST_HDR: begin
        if (hdr_hs) begin
          // A one-beat frame can finish in the same cycle as its header.
          if (last_hs) begin
            enable_d = 1'b0;
            grant_d  = '0;
            busy_d   = 1'b0;
            count_d  = count_q + 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (last_hs) begin
          enable_d = 1'b0;
          grant_d  = '0;
          busy_d   = 1'b0;
          count_d  = count_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
      select_q <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      count_q  <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      select_q <= select_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
    end
  end

  assign bus.enable      = enable_q;
  assign bus.select      = select_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.grant_count = count_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: two instances (16-bit and 2-bit frame counters)
// share the same stimulus; a monitor checks them against a frame-level model.
module tb_udp_tx_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic       hv, hr, tv, tr, tl;
  logic [1:0] st, stw;

  udp_tx_arbiter_if #(.S_COUNT(4), .COUNT_WIDTH(16)) bus ();
  udp_tx_arbiter_if #(.S_COUNT(4), .COUNT_WIDTH(2))  busw ();

  assign bus.req_hdr_valid  = req;
  assign bus.m_hdr_valid    = hv;
  assign bus.m_hdr_ready    = hr;
  assign bus.m_tvalid       = tv;
  assign bus.m_tready       = tr;
  assign bus.m_tlast        = tl;
  assign busw.req_hdr_valid = req;
  assign busw.m_hdr_valid   = hv;
  assign busw.m_hdr_ready   = hr;
  assign busw.m_tvalid      = tv;
  assign busw.m_tready      = tr;
  assign busw.m_tlast       = tl;

  udp_tx_arbiter #(.S_COUNT(4), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .state_o(st));
  udp_tx_arbiter #(.S_COUNT(4), .COUNT_WIDTH(2)) dut_w (
    .clk(clk), .reset_n(reset_n), .bus(busw.slave), .state_o(stw));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [1:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         m_ptr = 0;
  int         exp_count = 0;
  logic       exp_busy = 1'b0;
  logic       prev_busy = 1'b0;
  logic [1:0] cur_sel = 2'd0;
  logic [3:0] oh;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference rule: first requesting index at or after the pointer, with wrap.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_busy = 1'b0;
    end else begin
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("enable", 32'(bus.enable), 32'(exp_busy));
      chk("busy_w", 32'(busw.busy), 32'(exp_busy));
      chk("state_idle", 32'(st == 2'd0), 32'(!exp_busy));
      if (bus.busy && !prev_busy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_grant actual=sel%0d expected=none at %0t", bus.select, $time);
        end else begin
          cur_sel = exp_q.pop_front();
          oh = 4'b0001 << cur_sel;
          chk("grant_select", 32'(bus.select), 32'(cur_sel));
          chk("grant_onehot", 32'(bus.grant), 32'(oh));
          chk("grant_select_w", 32'(busw.select), 32'(cur_sel));
        end
      end else if (bus.busy) begin
        chk("select_stable", 32'(bus.select), 32'(cur_sel));
        chk("grant_stable", 32'(bus.grant), 32'(oh));
      end else begin
        chk("grant_idle", 32'(bus.grant), 32'd0);
      end
      if (!bus.busy && prev_busy) begin
        chk("grant_count", 32'(bus.grant_count), 32'(exp_count % 65536));
        chk("grant_count_w", 32'(busw.grant_count), 32'(exp_count % 4));
      end
      prev_busy = bus.busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_bus();
    hv = 1'b0; hr = 1'b0; tv = 1'b0; tr = 1'b0; tl = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge while the arbiter is idle.
  task automatic run_frame(input logic [3:0] pat, input int beats, input bit one_beat);
    int w;
    w = pick(pat, m_ptr);
    exp_q.push_back(2'(w));
    m_ptr = (w + 1) % 4;
    req = pat;
    step();
    exp_busy = 1'b1;
    req = 4'($urandom_range(0, 15));
    repeat ($urandom_range(0, 2)) begin
      hv = 1'($urandom_range(0, 1));
      hr = 1'b0;
      step();
    end
    if (one_beat) begin
      hv = 1'b1; hr = 1'b1; tv = 1'b1; tr = 1'b1; tl = 1'b1;
      exp_count++;
      step();
    end else begin
      hv = 1'b1; hr = 1'b1;
      step();
      hv = 1'b0; hr = 1'b0;
      for (int b = 0; b < beats; b++) begin
        repeat ($urandom_range(0, 2)) begin
          tv = 1'($urandom_range(0, 1));
          tr = 1'b0;
          tl = 1'($urandom_range(0, 1));
          req = 4'($urandom_range(0, 15));
          step();
        end
        tv = 1'b1; tr = 1'b1; tl = (b == beats - 1);
        if (b == beats - 1) exp_count++;
        step();
        clear_bus();
      end
    end
    clear_bus();
    exp_busy = 1'b0;
    req = 4'd0;
  endtask

  // Idle cycles with no requests; stray handshakes must not start a frame.
  task automatic idle_noise(input int n);
    repeat (n) begin
      req = 4'd0;
      hv = 1'($urandom_range(0, 1)); hr = 1'($urandom_range(0, 1));
      tv = 1'($urandom_range(0, 1)); tr = 1'($urandom_range(0, 1));
      tl = 1'($urandom_range(0, 1));
      step();
    end
    clear_bus();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_enable"}, 32'(bus.enable), 32'd0);
    chk({tag, "_select"}, 32'(bus.select), 32'd0);
    chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_count"}, 32'(bus.grant_count), 32'd0);
    chk({tag, "_count_w"}, 32'(busw.grant_count), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    req = 4'd0;
    clear_bus();
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single request with a 3-beat payload.
    run_frame(4'b0100, 3, 1'b0);
    idle_noise(2);

    // Reset asserted between edges in the middle of a payload.
    req = 4'b0010;
    exp_q.push_back(2'd1);
    step();
    exp_busy = 1'b1;
    hv = 1'b1; hr = 1'b1;
    step();
    clear_bus();
    tv = 1'b1; tr = 1'b1;
    step();
    #2;
    reset_n = 1'b0;
    exp_busy = 1'b0;
    exp_q.delete();
    m_ptr = 0;
    exp_count = 0;
    #1;
    chk_all_zero("async_reset");
    clear_bus();
    req = 4'd0;
    step();
    reset_n = 1'b1;

    // Fairness: all four requesting for eight frames, order 0,1,2,3,0,1,2,3.
    for (int f = 0; f < 8; f++) run_frame(4'b1111, 1 + (f % 3), 1'b0);

    // Skip idle requesters: ptr 0 -> grant 0, then 1001 gives 3 then 0.
    run_frame(4'b0001, 2, 1'b0);
    run_frame(4'b1001, 2, 1'b0);
    run_frame(4'b1001, 1, 1'b0);

    // Header and last beat accepted in the same cycle.
    run_frame(4'b0100, 1, 1'b1);
    idle_noise(1);

    // Randomized frames, including back-to-back and one-beat frames.
    for (int f = 0; f < 40; f++) begin
      run_frame(4'($urandom_range(1, 15)), $urandom_range(1, 5), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_noise($urandom_range(1, 3));
    end

    idle_noise(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
